// File: rtl/weld_sensor_sampler_if.sv
// ----------------------------------------------------------------------------
// weld_sensor_sampler_if
// Request/acknowledge link between the weld sensor sampler and the shared
// 3-channel ADC front-end.
//   adc_req  : conversion request, driven by the sampler
//   adc_ch   : channel select (0=temperature, 1=pressure, 2=voltage)
//   adc_ack  : data-valid acknowledge, driven by the ADC
//   adc_data : conversion result, valid while adc_req & adc_ack
// Modports: master = sampler side, slave = ADC side.
// ----------------------------------------------------------------------------
interface weld_sensor_sampler_if #(
   parameter int DATA_W = 16
);
   logic              adc_req;
   logic [1:0]        adc_ch;
   logic              adc_ack;
   logic [DATA_W-1:0] adc_data;

   modport master (
      output adc_req,
      output adc_ch,
      input  adc_ack,
      input  adc_data
   );

   modport slave (
      input  adc_req,
      input  adc_ch,
      output adc_ack,
      output adc_data
   );
endinterface

// File: rtl/weld_sensor_sampler.sv
// ----------------------------------------------------------------------------
// weld_sensor_sampler
// Periodically walks the shared ADC through temperature, pressure and voltage
// conversions and publishes the three results together as one coherent frame.
// Flags ADC handshakes that never complete and frame-start ticks that arrive
// while a frame is still being gathered.
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   enable         : runs the sample-period counter
//   clear_err      : one-cycle clear of the sticky error flags
//   adc            : ADC request/acknowledge link (master side)
//   temperature,
//   pressure,
//   voltage        : last published frame
//   frame_valid    : one-cycle strobe when a new frame is published
//   frame_count    : number of frames published (wraps)
//   timeout_err    : sticky, an ADC handshake timed out
//   overrun_err    : sticky, a tick arrived while a frame was in progress
//   busy           : a frame is in progress
// ----------------------------------------------------------------------------
module weld_sensor_sampler #(
   parameter int DATA_W  = 16,
   parameter int PERIOD  = 100,
   parameter int TIMEOUT = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 clear_err,
   weld_sensor_sampler_if.master adc,
   output logic [DATA_W-1:0]    temperature,
   output logic [DATA_W-1:0]    pressure,
   output logic [DATA_W-1:0]    voltage,
   output logic                 frame_valid,
   output logic [31:0]          frame_count,
   output logic                 timeout_err,
   output logic                 overrun_err,
   output logic                 busy
);

   localparam int CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam int WAIT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0]  PERIOD_LAST = CNT_W'(PERIOD - 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST   = WAIT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      GAP   = 2'd2,
      ERROR = 2'd3
   } state_t;

   state_t              state_reg, state_next;
   logic [CNT_W-1:0]    period_reg;
   logic [WAIT_W-1:0]   wait_reg, wait_next;
   logic [1:0]          ch_reg, ch_next;
   logic                req_reg, req_next;
   logic [DATA_W-1:0]   temp_shadow_reg;
   logic [DATA_W-1:0]   pres_shadow_reg;
   logic                tick;
   logic                capture;
   logic                publish;
   logic                timeout_hit;
   logic                overrun_hit;

   assign adc.adc_req = req_reg;
   assign adc.adc_ch  = ch_reg;
   assign busy        = (state_reg != IDLE);

   // Frame-start tick: last count of the period while enabled. Holding the
   // counter at 0 while disabled makes the first tick land on the PERIOD-th
   // enabled cycle.
   assign tick        = enable && (period_reg == PERIOD_LAST);
   assign overrun_hit = tick && (state_reg != IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         period_reg <= '0;
      end else if (!enable || (period_reg == PERIOD_LAST)) begin
         period_reg <= '0;
      end else begin
         period_reg <= period_reg + 1'b1;
      end
   end

   // Next-state / handshake control. The request line is registered, so
   // every transition computes the value adc_req takes after the edge.
   always_comb begin
      state_next  = state_reg;
      req_next    = req_reg;
      ch_next     = ch_reg;
      wait_next   = wait_reg;
      capture     = 1'b0;
      publish     = 1'b0;
      timeout_hit = 1'b0;
      case (state_reg)
         IDLE: begin
            if (tick) begin
               state_next = REQ;
               req_next   = 1'b1;
               ch_next    = 2'd0;
               wait_next  = '0;
            end
         end
         REQ: begin
            // An ack in the final allowed cycle still counts as a capture.
            if (adc.adc_ack) begin
               capture  = 1'b1;
               req_next = 1'b0;
               if (ch_reg == 2'd2) begin
                  publish    = 1'b1;
                  state_next = IDLE;
               end else begin
                  state_next = GAP;
               end
            end else if (wait_reg == WAIT_LAST) begin
               timeout_hit = 1'b1;
               req_next    = 1'b0;
               state_next  = ERROR;
            end else begin
               wait_next = wait_reg + 1'b1;
            end
         end
         GAP: begin
            // Forces adc_req low for one cycle between channels.
            state_next = REQ;
            req_next   = 1'b1;
            ch_next    = ch_reg + 2'd1;
            wait_next  = '0;
         end
         ERROR: begin
            state_next = IDLE;
            req_next   = 1'b0;
         end
         default: begin
            state_next = IDLE;
            req_next   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg       <= IDLE;
         req_reg         <= 1'b0;
         ch_reg          <= 2'd0;
         wait_reg        <= '0;
         temp_shadow_reg <= '0;
         pres_shadow_reg <= '0;
         temperature     <= '0;
         pressure        <= '0;
         voltage         <= '0;
         frame_valid     <= 1'b0;
         frame_count     <= '0;
         timeout_err     <= 1'b0;
         overrun_err     <= 1'b0;
      end else begin
         state_reg   <= state_next;
         req_reg     <= req_next;
         ch_reg      <= ch_next;
         wait_reg    <= wait_next;
         frame_valid <= publish;

         // Samples are held in shadows so the published words only ever
         // change together, and an aborted frame leaves them untouched.
         if (capture && (ch_reg == 2'd0)) begin
            temp_shadow_reg <= adc.adc_data;
         end
         if (capture && (ch_reg == 2'd1)) begin
            pres_shadow_reg <= adc.adc_data;
         end

         // Voltage is the last channel, so it is published straight from
         // the ADC bus on the capturing edge.
         if (publish) begin
            temperature <= temp_shadow_reg;
            pressure    <= pres_shadow_reg;
            voltage     <= adc.adc_data;
            frame_count <= frame_count + 32'd1;
         end

         // A set event in the same cycle as clear_err keeps the flag set.
         timeout_err <= timeout_hit | (timeout_err & ~clear_err);
         overrun_err <= overrun_hit | (overrun_err & ~clear_err);
      end
   end

endmodule
